// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants and elaboration helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_adapter_pkg;

  // Deepest FIFO read latency the in-flight tracker is built for.
  localparam int unsigned MAX_RD_LAT = 4;

  // Width of the in-flight read counter; must hold 0..MAX_RD_LAT.
  localparam int unsigned INFL_CNT_W = 3;

  // The skid buffer must absorb every word already requested plus the one
  // being captured, otherwise the credit check cannot keep the pipe full.
  function automatic bit params_ok(int unsigned rd_lat, int unsigned buf_aw);
    return (rd_lat <= MAX_RD_LAT) && (buf_aw >= 1) && ((1 << buf_aw) >= (rd_lat + 1));
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf.sv
// Circular word store with push/pop, occupancy count and combinational head.
module fifo_rd_stream_adapter_skid_buf #(
  parameter int unsigned dw     = 32,
  parameter int unsigned buf_aw = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [dw-1:0]     push_data,
  input  logic              pop,
  output logic [dw-1:0]     head,
  output logic [buf_aw:0]   count
);

  localparam int unsigned DEPTH = 1 << buf_aw;
  localparam int unsigned CNT_W = buf_aw + 1;

  logic [DEPTH-1:0][dw-1:0] mem;
  logic [buf_aw-1:0]        wr_ptr;
  logic [buf_aw-1:0]        rd_ptr;

  // Storage: cleared on reset so the head reads zero until the first capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers advance on their own events and wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + buf_aw'(1);
      if (pop)  rd_ptr <= rd_ptr + buf_aw'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

  // The upstream credit check must keep the store from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    count <= CNT_W'(DEPTH));

  // A push into a full store is only legal when a pop frees a slot in the same cycle.
  a_push_room: assert property (@(posedge clk) disable iff (!rstn)
    (push && !pop) |-> (count < CNT_W'(DEPTH)));

  // Popping an empty store would replay stale data.
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rstn)
    pop |-> (count != '0));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Reader end of a latency-rd_lat synchronous FIFO presented as a valid/ready
// stream. Reads are issued only against free skid-buffer credit, so the FIFO
// is never popped while empty and the buffer never overflows.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int unsigned dw     = 32,
  parameter int unsigned rd_lat = 1,
  parameter int unsigned buf_aw = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [dw-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [dw-1:0] m_data,
  output logic          idle
);

  localparam int unsigned BUF_DEPTH = 1 << buf_aw;
  localparam int unsigned CNT_W     = buf_aw + 1;
  localparam int unsigned CRD_W     = CNT_W + INFL_CNT_W;

  if (!params_ok(rd_lat, buf_aw)) begin : g_param_chk
    $error("fifo_rd_stream_adapter: need rd_lat<=4, buf_aw>=1 and (1<<buf_aw) >= rd_lat+1");
  end

  logic                  pop;
  logic                  arrive;
  logic [INFL_CNT_W-1:0] n_infl;
  logic [CNT_W-1:0]      buf_cnt;
  logic [CRD_W-1:0]      credit_used;
  logic [CRD_W-1:0]      credit_lim;

  assign pop = m_valid & m_ready;

  // Words held plus words owed must stay below the depth, with a same-cycle pop
  // counting as a freed slot (compared without subtraction to avoid underflow).
  assign credit_used = CRD_W'(buf_cnt) + CRD_W'(n_infl);
  assign credit_lim  = CRD_W'(BUF_DEPTH) + CRD_W'(pop);

  // rstn gating keeps the pop request low for the whole reset window.
  assign fifo_rd_en  = rstn & ~fifo_empty & (credit_used < credit_lim);

  if (rd_lat == 0) begin : g_lat0
    // Zero-latency FIFO: data is captured in the cycle it is requested.
    assign arrive = fifo_rd_en;
    assign n_infl = '0;
  end else begin : g_latn
    localparam int unsigned LAT_W = rd_lat;

    logic [LAT_W-1:0] infl;

    // In-flight tracker: one bit per outstanding read, oldest at the MSB.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        infl <= '0;
      end else begin
        infl <= LAT_W'({infl, fifo_rd_en});
      end
    end

    assign arrive = infl[LAT_W-1];
    assign n_infl = INFL_CNT_W'($countones(infl));
  end

  fifo_rd_stream_adapter_skid_buf #(
    .dw     (dw),
    .buf_aw (buf_aw)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (arrive),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .count     (buf_cnt)
  );

  assign m_valid = (buf_cnt != '0);
  assign idle    = (buf_cnt == '0) & (n_infl == '0);

endmodule
